// File: rtl/wb_arbiter.sv
// rtl/wb_arbiter.sv - regfile write-port arbiter merging pipeline and long-latency results (optional WB_ARBITER_STATS_EN)
module wb_arbiter #(
  parameter int DEPTH = 4,
  parameter int AW    = 5,
  parameter int DW    = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             p_wreg,
  input  logic [AW-1:0]    p_waddr,
  input  logic [DW-1:0]    p_wdata,
  input  logic             l_valid,
  output logic             l_ready,
  input  logic [AW-1:0]    l_waddr,
  input  logic [DW-1:0]    l_wdata,
  output logic             we,
  output logic [AW-1:0]    waddr,
  output logic [DW-1:0]    wdata,
  output logic [2**AW-1:0] busy_mask,
  output logic [31:0]      stat_stall,
  output logic [31:0]      stat_squash
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  logic [CW-1:0]    r_count;
  logic [PW-1:0]    r_rptr;
  logic [PW-1:0]    r_wptr;
  logic [DEPTH-1:0] r_live;
  logic [AW-1:0]    r_addr [DEPTH];
  logic [DW-1:0]    r_data [DEPTH];
  logic             r_we;
  logic [AW-1:0]    r_waddr;
  logic [DW-1:0]    r_wdata;

  logic             w_ready;
  logic             w_pwin;
  logic             w_pop;
  logic             w_accept;
  logic             w_push;
  logic             w_in_live;
  logic [DEPTH-1:0] w_kill;
  logic [DEPTH-1:0] w_live_nxt;
  logic [2**AW-1:0] w_busy;

  // Ready comes from registered occupancy only, held low while in reset.
  assign w_ready   = rst && (r_count < CW'(DEPTH));
  assign l_ready   = w_ready;
  assign w_pwin    = p_wreg && (p_waddr != '0);
  assign w_pop     = !w_pwin && (r_count != '0);
  assign w_accept  = l_valid && w_ready;
  assign w_push    = w_accept && (l_waddr != '0);
  assign w_in_live = !(w_pwin && (l_waddr == p_waddr));

  // Younger pipeline write squashes queued entries to the same register, then pop/push adjust slots.
  always_comb begin
    w_kill     = '0;
    w_live_nxt = '0;
    for (int i = 0; i < DEPTH; i++) begin
      w_kill[i] = w_pwin && r_live[i] && (r_addr[i] == p_waddr);
    end
    w_live_nxt = r_live & ~w_kill;
    if (w_pop) w_live_nxt[r_rptr] = 1'b0;
    if (w_push) w_live_nxt[r_wptr] = w_in_live;
  end

  // Busy mask covers only live queued entries; x0 is never busy.
  always_comb begin
    w_busy = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (r_live[i]) w_busy[r_addr[i]] = 1'b1;
    end
    w_busy[0] = 1'b0;
  end

  // FIFO control: pointers, occupancy and live bits.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_count <= '0;
      r_rptr  <= '0;
      r_wptr  <= '0;
      r_live  <= '0;
    end else begin
      r_live <= w_live_nxt;
      if (w_push) r_wptr <= r_wptr + PW'(1);
      if (w_pop)  r_rptr <= r_rptr + PW'(1);
      if (w_push && !w_pop)      r_count <= r_count + CW'(1);
      else if (!w_push && w_pop) r_count <= r_count - CW'(1);
    end
  end

  // FIFO payload storage; contents are meaningless unless the live/count state says otherwise.
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_addr[r_wptr] <= l_waddr;
      r_data[r_wptr] <= l_wdata;
    end
  end

  // Registered write port: pipeline first, then FIFO head, else idle with held address/data.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_we    <= 1'b0;
      r_waddr <= '0;
      r_wdata <= '0;
    end else if (w_pwin) begin
      r_we    <= 1'b1;
      r_waddr <= p_waddr;
      r_wdata <= p_wdata;
    end else if (w_pop) begin
      r_we    <= r_live[r_rptr];
      r_waddr <= r_addr[r_rptr];
      r_wdata <= r_data[r_rptr];
    end else begin
      r_we    <= 1'b0;
    end
  end

  assign we        = r_we;
  assign waddr     = r_waddr;
  assign wdata     = r_wdata;
  assign busy_mask = w_busy;

`ifdef WB_ARBITER_STATS_EN
  logic [31:0] r_stall;
  logic [31:0] r_squash;
  logic [CW-1:0] w_kill_cnt;
  logic [32:0] w_sq_sum;

  // Squash increment: cleared live entries plus an incoming result stored dead.
  always_comb begin
    w_kill_cnt = '0;
    for (int i = 0; i < DEPTH; i++) begin
      w_kill_cnt = w_kill_cnt + CW'(w_kill[i]);
    end
    w_sq_sum = {1'b0, r_squash} + 33'(w_kill_cnt) + 33'(w_push && !w_in_live);
  end

  // Saturating stall and squash counters.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_stall  <= '0;
      r_squash <= '0;
    end else begin
      if (l_valid && !w_ready && (r_stall != 32'hFFFF_FFFF)) r_stall <= r_stall + 32'd1;
      r_squash <= w_sq_sum[32] ? 32'hFFFF_FFFF : w_sq_sum[31:0];
    end
  end

  assign stat_stall  = r_stall;
  assign stat_squash = r_squash;
`else
  assign stat_stall  = '0;
  assign stat_squash = '0;
`endif

endmodule

// File: doc/wb_arbiter.md
Name: wb_arbiter

Overview:
- Sits directly upstream of the regfile write port and owns that port (`we`/`waddr`/`wdata`).
- Merges two result sources:
  - in-order pipeline results from the MEM/WB stage, which cannot be stalled;
  - out-of-order long-latency results (divider, multi-cycle loads), which have a valid/ready handshake.
- Long results wait in a small FIFO and drain into idle write-port cycles.
- Exports a busy mask so the ID stage can stall on registers with queued writes.

Parameters:
- DEPTH, 4, long-result FIFO entries; power of 2, >= 2.
- AW, 5, register address width.
- DW, 32, register data width.

Ports:
- clk  in  1  system clock.
- rst  in  1  asynchronous, active-low reset (0 = reset asserted).
- p_wreg  in  1  pipeline write request this cycle.
- p_waddr  in  AW  pipeline destination register.
- p_wdata  in  DW  pipeline result.
- l_valid  in  1  long-latency result valid.
- l_ready  out  1  FIFO can accept a long result.
- l_waddr  in  AW  long-result destination register.
- l_wdata  in  DW  long result.
- we  out  1  regfile write enable (registered).
- waddr  out  AW  regfile write address (registered).
- wdata  out  DW  regfile write data (registered).
- busy_mask  out  2^AW  bit i = a live queued write targets register i.
- stat_stall  out  32  cycles with l_valid=1 and l_ready=0 (optional feature).
- stat_squash  out  32  queued entries squashed (optional feature).

Behaviour:
- Reset (`rst`=0, takes effect asynchronously):
  - we=0, waddr=0, wdata=0.
  - FIFO empty, all entry live bits cleared, busy_mask=0.
  - l_ready=0 while reset is asserted; stat counters = 0.
- Handshake:
  - l_ready = (count < DEPTH), decoded from registered count only; no combinational path from dequeue.
  - A long result is accepted on a clock edge where l_valid=1 and l_ready=1.
  - l_waddr=0 is accepted but not enqueued.
- Each FIFO entry holds {live, addr, data}.
- Port priority, evaluated per cycle and registered to outputs at the next edge:
  - p_wreg=1 and p_waddr!=0: output {1, p_waddr, p_wdata}. The pipeline result always wins, so pipeline latency is exactly 1 cycle.
  - Otherwise, if FIFO non-empty: pop the head and output {head.live, head.addr, head.data}. A squashed head pops with we=0.
  - Otherwise: we=0. waddr/wdata hold their previous values.
- A p_wreg write to x0 is dropped: it yields we=0 and lets the FIFO drain that cycle.
- Minimum long-result latency is 2 cycles (enqueue edge, then drain edge).
- Enqueue and dequeue on the same edge are legal; count is unchanged.
- Ordering rule (the younger pipeline write wins):
  - A pipeline write with p_waddr=A (A!=0) clears the live bit of every queued entry with addr=A on the same edge.
  - A long result enqueued on that same edge with l_waddr=A is stored with live=0.
  - Squashed entries still occupy their slot until drained.
- busy_mask: OR over queued entries with live=1 of onehot(addr). Decoded from registered state only; bit 0 is always 0.
- Full FIFO with a pipeline write every cycle: nothing drains, and l_ready stays 0 indefinitely.
- Read/write pointers wrap modulo DEPTH; count ranges 0..DEPTH.
- Reset mid-operation discards every queued entry, and no write is emitted for them.

Optional Feature:
- Macro: WB_ARBITER_STATS_EN.
- Defined:
  - stat_stall increments each cycle with l_valid=1 and l_ready=0.
  - stat_squash increments by the number of live entries cleared on that edge, plus 1 if an incoming long result is stored squashed.
  - Both counters saturate at 32'hFFFFFFFF and reset to 0.
- Undefined: no counter logic; stat_stall and stat_squash are tied to 0.

Test Plan:
- Pipeline only: p_wreg=1, p_waddr=5, p_wdata=32'h1234 at cycle N -> we=1, waddr=5, wdata=32'h1234 at N+1; busy_mask stays 0.
- Long drain: l_valid=1, l_waddr=7, l_wdata=32'hAA at N, no pipeline writes -> busy_mask[7]=1 after edge N; we=1, waddr=7, wdata=32'hAA at N+2; busy_mask=0 afterwards.
- Fill/backpressure: 4 long results while pipeline writes x1 every cycle -> l_ready=0 after the 4th; pipeline idle for one cycle -> one pop, l_ready=1 the following cycle; stat_stall counts the stalled cycles (STATS_EN).
- Squash: queue {x9, 32'h11}; next cycle pipeline writes x9=32'h22 -> output x9=32'h22; busy_mask[9]=0; the queued entry later drains with we=0; stat_squash=1.
- x0 handling: p_wreg=1 with p_waddr=0 alongside a queued x3 entry -> x3 drains that cycle; long result to x0 -> accepted, never written, count unchanged.
- Async reset: assert rst=0 mid-cycle with 3 entries queued -> we=0 and busy_mask=0 immediately; after release, no stale write appears and l_ready=1.
